// File: rtl/pc_ctrl.sv
// Program-counter and fetch-control stage: owns the PC, sequences IDLE -> RUN -> DONE,
// and counts retired instructions with a saturating counter.
module pc_ctrl #(
   parameter int                PC_W     = 12,
   parameter logic [PC_W-1:0]   START_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              jump_en,
   input  logic              branch_en,
   input  logic              cond_flag,
   input  logic              halt,
   input  logic [PC_W-1:0]   target,
   output logic [PC_W-1:0]   pc,
   output logic              running,
   output logic              done,
   output logic [CNT_W-1:0]  retired
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [PC_W-1:0]   pc_nx;
   logic [CNT_W-1:0]  ret_nx;
   logic [CNT_W-1:0]  ret_inc;

   // Counter sticks at all-ones so long programs never look short.
   assign ret_inc = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

   always_comb begin
      // NOTE: every next-value gets a hold default first so no path infers a latch.
      state_nx = state;
      pc_nx    = pc;
      ret_nx   = retired;
      unique case (state)
         IDLE: begin
            pc_nx  = START_PC;
            ret_nx = '0;
            if (start) state_nx = RUN;
         end
         RUN: begin
            // Stall freezes everything; halt leaves pc on the halt instruction.
            if (!stall) begin
               ret_nx = ret_inc;
               if (halt)
                  state_nx = DONE;
               else if (jump_en || (branch_en && cond_flag))
                  pc_nx = target;
               else
                  pc_nx = pc + PC_W'(1);
            end
         end
         DONE: begin
            if (start) begin
               state_nx = RUN;
               pc_nx    = START_PC;
               ret_nx   = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (reset) begin
         state   <= IDLE;
         pc      <= START_PC;
         retired <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         pc      <= pc_nx;
         retired <= ret_nx;
         running <= (state_nx == RUN);
         done    <= (state_nx == DONE);
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: vector table driven through a scoreboard queue,
// plus hand sequences for asynchronous reset and restart from DONE.
module tb_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0, stall = 1'b0, jump_en = 1'b0, branch_en = 1'b0;
   logic        cond_flag = 1'b0, halt = 1'b0;
   logic [11:0] target = '0;
   logic [11:0] pc, pc2;
   logic        running, done, running2, done2;
   logic [15:0] retired;
   logic [3:0]  retired2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc_ctrl #(.PC_W(12), .START_PC(12'd0), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .jump_en(jump_en),
      .branch_en(branch_en), .cond_flag(cond_flag), .halt(halt), .target(target),
      .pc(pc), .running(running), .done(done), .retired(retired)
   );

   // Narrow counter copy, driven identically, to exercise saturation.
   pc_ctrl #(.PC_W(12), .START_PC(12'd0), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .jump_en(jump_en),
      .branch_en(branch_en), .cond_flag(cond_flag), .halt(halt), .target(target),
      .pc(pc2), .running(running2), .done(done2), .retired(retired2)
   );

   typedef struct {
      logic        start, stall, jump_en, branch_en, cond_flag, halt;
      logic [11:0] target;
      int          pc;
      logic        running, done;
      int          ret;
   } vec_t;

   typedef struct {
      int   pc;
      logic running, done;
      int   ret;
   } exp_t;

   vec_t tbl[$];
   exp_t exp_q[$];

   task automatic check(input string nm, input longint act, input longint req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic v(input logic st, sl, j, b, c, h, input int tg,
                    input int epc, input logic er, ed, input int eret);
      vec_t t;
      t.start = st; t.stall = sl; t.jump_en = j; t.branch_en = b;
      t.cond_flag = c; t.halt = h; t.target = 12'(tg);
      t.pc = epc; t.running = er; t.done = ed; t.ret = eret;
      tbl.push_back(t);
   endtask

   // Called on a falling edge: drive, queue expectation, compare after the next rise.
   task automatic apply(input vec_t t, input string nm);
      exp_t e;
      start = t.start; stall = t.stall; jump_en = t.jump_en; branch_en = t.branch_en;
      cond_flag = t.cond_flag; halt = t.halt; target = t.target;
      exp_q.push_back('{t.pc, t.running, t.done, t.ret});
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check({nm, " pc"}, pc, e.pc);
      check({nm, " running"}, running, e.running);
      check({nm, " done"}, done, e.done);
      check({nm, " retired"}, retired, e.ret);
      check({nm, " retired4"}, retired2, (e.ret > 15) ? 15 : e.ret);
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, " pc"}, pc, 0);
      check({nm, " running"}, running, 0);
      check({nm, " done"}, done, 0);
      check({nm, " retired"}, retired, 0);
      check({nm, " retired4"}, retired2, 0);
   endtask

   initial begin
      vec_t t;
      // Fields: start stall jump branch cond halt target | pc running done retired
      v(0,0,1,0,0,0,99,     0,0,0,0);      // IDLE ignores jump
      v(1,0,0,0,0,0,0,      0,1,0,0);      // start
      for (int i = 1; i <= 9; i++) v(0,0,0,0,0,0,0, i,1,0,i);
      v(1,0,0,0,0,0,0,      10,1,0,10);    // start ignored in RUN
      v(0,0,1,0,0,0,507,    507,1,0,11);
      v(0,0,0,0,0,0,0,      508,1,0,12);
      v(0,0,1,0,0,0,20,     20,1,0,13);
      v(0,0,0,1,0,0,385,    21,1,0,14);    // branch not taken
      v(0,0,0,1,1,0,385,    385,1,0,15);   // branch taken
      v(0,0,1,1,1,0,1134,   1134,1,0,16);
      v(0,0,1,0,0,0,4095,   4095,1,0,17);
      v(0,0,0,0,0,0,0,      0,1,0,18);     // wrap
      v(0,0,0,0,0,0,0,      1,1,0,19);
      v(0,0,1,0,0,0,0,      0,1,0,20);     // target 0 is legal
      v(0,0,0,0,0,0,0,      1,1,0,21);
      v(0,0,0,0,0,0,0,      2,1,0,22);
      for (int i = 0; i < 3; i++) v(0,1,1,0,0,1,77, 2,1,0,22);  // stall wins
      v(0,0,1,0,0,1,77,     2,0,1,23);     // halt beats jump
      v(0,0,1,0,0,0,9,      2,0,1,23);     // DONE holds
      v(1,0,0,0,0,0,0,      0,1,0,0);      // restart
      v(0,0,0,0,0,0,0,      1,1,0,1);
      v(0,0,0,0,0,0,0,      2,1,0,2);

      #2 reset = 1'b1;
      #1 check_reset_vals("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset between edges during RUN must clear outputs without a clock.
      #2 reset = 1'b1;
      #1 check_reset_vals("async_reset");
      @(negedge clk);
      reset = 1'b0;
      t = '{0,0,0,0,0,0,12'd0, 0,1'b0,1'b0,0};
      apply(t, "post_reset_idle");
      t = '{1,0,0,0,0,0,12'd0, 0,1'b1,1'b0,0};
      apply(t, "start2");
      t = '{0,0,0,0,0,1,12'd0, 0,1'b0,1'b1,1};
      apply(t, "halt_first");
      t = '{1,0,1,0,0,0,12'd300, 0,1'b1,1'b0,0};
      apply(t, "restart_from_done");
      t = '{0,0,0,0,0,0,12'd0, 1,1'b1,1'b0,1};
      apply(t, "run_after_restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
